// File: rtl/periodo_pkg.sv
// -----------------------------------------------------------------------------
// periodo_pkg
// Definitions shared by the signal-period generator and the signal-period
// counter, so that both blocks agree on field widths and on FSM encoding.
//   CNT_W_DEF  : default width of period / high-time fields (12 bits).
//   NPER_W_DEF : default width of the period-count field (8 bits).
//   state_e    : generator FSM states (IDLE, HIGH, LOW).
// -----------------------------------------------------------------------------
package periodo_pkg;

    localparam int CNT_W_DEF  = 12;
    localparam int NPER_W_DEF = 8;

    // Fixed encodings so a waveform or checker can decode the state directly.
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_HIGH_ENC = 2'd1;
    localparam logic [1:0] ST_LOW_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_HIGH = ST_HIGH_ENC,
        ST_LOW  = ST_LOW_ENC
    } state_e;

endpackage

// File: rtl/signal_period_generator.sv
// -----------------------------------------------------------------------------
// signal_period_generator
// Emits a registered square wave `sinal` with period P and high time H, both
// measured in clocks, for N periods (N = 0 means run until stop).
//
// Handshake: `start` is a single-cycle request, looked at only while IDLE;
// `stop` is looked at only while HIGH or LOW and wins over a period that
// completes in the same cycle. There is no back-pressure: a request seen in a
// state that samples it takes effect on the next rising clock edge.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   begin emission (IDLE only)
//   stop          in   abort emission (HIGH/LOW only)
//   period_clocks in   P, total period in clocks   [CNT_W]
//   high_clocks   in   H, high time in clocks      [CNT_W]
//   num_periods   in   N, periods to emit, 0=forever [NPER_W]
//   sinal         out  generated waveform (registered)
//   busy          out  emitting (HIGH or LOW)
//   done          out  one-cycle pulse on completion or on an accepted stop
//   cfg_error     out  sticky flag for a rejected start
//   periods_done  out  full periods completed since last accepted start [NPER_W]
// -----------------------------------------------------------------------------
module signal_period_generator
    import periodo_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int NPER_W = NPER_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  period_clocks,
    input  logic [CNT_W-1:0]  high_clocks,
    input  logic [NPER_W-1:0] num_periods,
    output logic              sinal,
    output logic              busy,
    output logic              done,
    output logic              cfg_error,
    output logic [NPER_W-1:0] periods_done
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0]  high_q, high_d;      // latched H
    logic [CNT_W-1:0]  low_q, low_d;        // latched P-H
    logic [NPER_W-1:0] nper_q, nper_d;      // latched N
    logic [NPER_W-1:0] pdone_q, pdone_d;
    logic              sinal_q, sinal_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              cfg_legal;
    logic [NPER_W-1:0] pdone_inc;

    // 2 <= P and 1 <= H <= P-1; H < P covers the upper bound without a subtract.
    assign cfg_legal = (period_clocks >= CNT_W'(2)) &&
                       (high_clocks != '0) &&
                       (high_clocks < period_clocks);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        high_d    = high_q;
        low_d     = low_q;
        nper_d    = nper_q;
        pdone_d   = pdone_q;
        sinal_d   = sinal_q;
        done_d    = 1'b0;
        cfg_err_d = cfg_err_q;
        pdone_inc = pdone_q + NPER_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_legal) begin
                        high_d    = high_clocks;
                        // Never negative: legality guarantees H < P.
                        low_d     = period_clocks - high_clocks;
                        nper_d    = num_periods;
                        pdone_d   = '0;
                        cfg_err_d = 1'b0;
                        phase_d   = CNT_W'(1);
                        sinal_d   = 1'b1;
                        state_d   = ST_HIGH;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            ST_HIGH: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    sinal_d = 1'b0;
                    done_d  = 1'b1;
                end else if (phase_q == high_q) begin
                    state_d = ST_LOW;
                    phase_d = CNT_W'(1);
                    sinal_d = 1'b0;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end

            ST_LOW: begin
                if (stop) begin
                    // Partial period is abandoned and not counted.
                    state_d = ST_IDLE;
                    phase_d = '0;
                    sinal_d = 1'b0;
                    done_d  = 1'b1;
                end else if (phase_q == low_q) begin
                    pdone_d = pdone_inc;
                    if ((nper_q != '0) && (pdone_inc == nper_q)) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                        sinal_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Next period starts immediately: no idle gap.
                        state_d = ST_HIGH;
                        phase_d = CNT_W'(1);
                        sinal_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                sinal_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            high_q    <= '0;
            low_q     <= '0;
            nper_q    <= '0;
            pdone_q   <= '0;
            sinal_q   <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            high_q    <= high_d;
            low_q     <= low_d;
            nper_q    <= nper_d;
            pdone_q   <= pdone_d;
            sinal_q   <= sinal_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign sinal        = sinal_q;
    assign busy         = (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign done         = done_q;
    assign cfg_error    = cfg_err_q;
    assign periods_done = pdone_q;

endmodule

// File: tb/tb_signal_period_generator.sv
// -----------------------------------------------------------------------------
// tb_signal_period_generator
// Directed bench for signal_period_generator. Inputs change on the falling
// edge; outputs are sampled on the falling edge, so each sample reflects the
// preceding rising edge. Sample index i means "after rising edge E_i", where
// E_0 is the edge that accepts start.
// -----------------------------------------------------------------------------
module tb_signal_period_generator;

    localparam int CNT_W  = 12;
    localparam int NPER_W = 8;

    logic              clock;
    logic              reset;
    logic              start;
    logic              stop;
    logic [CNT_W-1:0]  period_clocks;
    logic [CNT_W-1:0]  high_clocks;
    logic [NPER_W-1:0] num_periods;
    logic              sinal;
    logic              busy;
    logic              done;
    logic              cfg_error;
    logic [NPER_W-1:0] periods_done;

    int n_cmp;
    int n_err;

    signal_period_generator #(.CNT_W(CNT_W), .NPER_W(NPER_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .period_clocks (period_clocks),
        .high_clocks   (high_clocks),
        .num_periods   (num_periods),
        .sinal         (sinal),
        .busy          (busy),
        .done          (done),
        .cfg_error     (cfg_error),
        .periods_done  (periods_done)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        period_clocks = '0;
        high_clocks = '0;
        num_periods = '0;
        repeat (2) @(negedge clock);
        n_cmp++; if (sinal !== 1'b0) begin n_err++; $display("FAIL reset_sinal got=%b want=0", sinal); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (cfg_error !== 1'b0) begin n_err++; $display("FAIL reset_cfg_error got=%b want=0", cfg_error); end
        n_cmp++; if (periods_done !== 8'd0) begin n_err++; $display("FAIL reset_periods_done got=%0d want=0", periods_done); end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (sinal !== 1'b0) begin n_err++; $display("FAIL post_reset_sinal got=%b want=0", sinal); end
    endtask

    // P=10 H=5 N=2; stop asserted together with start must be ignored.
    task automatic test_basic();
        logic exp_s;
        period_clocks = 12'd10; high_clocks = 12'd5; num_periods = 8'd2;
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 0) begin start = 1'b0; stop = 1'b0; end
            exp_s = ((i % 10) < 5);
            n_cmp++; if (sinal !== exp_s) begin n_err++; $display("FAIL basic_sinal i=%0d got=%b want=%b", i, sinal, exp_s); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy i=%0d got=%b want=1", i, busy); end
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_early i=%0d got=%b want=0", i, done); end
            if (i == 10) begin
                n_cmp++; if (periods_done !== 8'd1) begin n_err++; $display("FAIL basic_pd_mid got=%0d want=1", periods_done); end
            end
        end
        @(negedge clock);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done got=%b want=1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got=%b want=0", busy); end
        n_cmp++; if (sinal !== 1'b0) begin n_err++; $display("FAIL basic_sinal_end got=%b want=0", sinal); end
        n_cmp++; if (periods_done !== 8'd2) begin n_err++; $display("FAIL basic_pd got=%0d want=2", periods_done); end
        @(negedge clock);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    endtask

    // P=4 H=3 N=3: 1110 x3 with no gaps; mid-run input changes and start ignored.
    task automatic test_back_to_back();
        logic exp_s;
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        period_clocks = 12'd4; high_clocks = 12'd3; num_periods = 8'd3;
        start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (i == 0) start = 1'b0;
            if (i == 5) begin
                period_clocks = 12'd7; high_clocks = 12'd1; num_periods = 8'd1; start = 1'b1;
            end
            if (i == 6) start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (i < 12) begin
                exp_s = ((i % 4) < 3);
                n_cmp++; if (sinal !== exp_s) begin n_err++; $display("FAIL b2b_sinal i=%0d got=%b want=%b", i, sinal, exp_s); end
            end
        end
        n_cmp++; if (busy_cnt !== 12) begin n_err++; $display("FAIL b2b_busy_cycles got=%0d want=12", busy_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL b2b_done_count got=%0d want=1", done_cnt); end
        n_cmp++; if (periods_done !== 8'd3) begin n_err++; $display("FAIL b2b_pd got=%0d want=3", periods_done); end
    endtask

    // Illegal configs are rejected; a following legal start clears the flag.
    task automatic test_illegal();
        logic [CNT_W-1:0] tab_p [3];
        logic [CNT_W-1:0] tab_h [3];
        tab_p[0] = 12'd5; tab_h[0] = 12'd5;
        tab_p[1] = 12'd1; tab_h[1] = 12'd0;
        tab_p[2] = 12'd8; tab_h[2] = 12'd0;
        for (int k = 0; k < 3; k++) begin
            period_clocks = tab_p[k]; high_clocks = tab_h[k]; num_periods = 8'd1;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            n_cmp++; if (cfg_error !== 1'b1) begin n_err++; $display("FAIL ill_cfg_error k=%0d got=%b want=1", k, cfg_error); end
            n_cmp++; if (sinal !== 1'b0) begin n_err++; $display("FAIL ill_sinal k=%0d got=%b want=0", k, sinal); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ill_busy k=%0d got=%b want=0", k, busy); end
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ill_done k=%0d got=%b want=0", k, done); end
            @(negedge clock);
            n_cmp++; if (cfg_error !== 1'b1) begin n_err++; $display("FAIL ill_sticky k=%0d got=%b want=1", k, cfg_error); end
            // legal P=2 H=1 N=1 clears it
            period_clocks = 12'd2; high_clocks = 12'd1; num_periods = 8'd1;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            n_cmp++; if (cfg_error !== 1'b0) begin n_err++; $display("FAIL ill_clear k=%0d got=%b want=0", k, cfg_error); end
            n_cmp++; if (sinal !== 1'b1) begin n_err++; $display("FAIL ill_resume k=%0d got=%b want=1", k, sinal); end
            @(negedge clock);
            n_cmp++; if (sinal !== 1'b0) begin n_err++; $display("FAIL ill_low k=%0d got=%b want=0", k, sinal); end
            @(negedge clock);
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ill_done_legal k=%0d got=%b want=1", k, done); end
        end
    endtask

    // P=10 H=3 N=0; stop during 4th LOW cycle of period 3 (sample index 26).
    task automatic test_stop();
        logic exp_s;
        period_clocks = 12'd10; high_clocks = 12'd3; num_periods = 8'd0;
        start = 1'b1;
        for (int i = 0; i <= 26; i++) begin
            @(negedge clock);
            if (i == 0) start = 1'b0;
            exp_s = ((i % 10) < 3);
            n_cmp++; if (sinal !== exp_s) begin n_err++; $display("FAIL stop_sinal i=%0d got=%b want=%b", i, sinal, exp_s); end
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        n_cmp++; if (sinal !== 1'b0) begin n_err++; $display("FAIL stop_sinal_end got=%b want=0", sinal); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stop_done got=%b want=1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got=%b want=0", busy); end
        n_cmp++; if (periods_done !== 8'd2) begin n_err++; $display("FAIL stop_pd got=%0d want=2", periods_done); end
        @(negedge clock);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stop_done_pulse got=%b want=0", done); end
    endtask

    // stop coincides with the completing cycle of the last period: stop wins.
    task automatic test_stop_priority();
        period_clocks = 12'd4; high_clocks = 12'd3; num_periods = 8'd1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 0) start = 1'b0;
        end
        n_cmp++; if (sinal !== 1'b0) begin n_err++; $display("FAIL prio_low got=%b want=0", sinal); end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL prio_done got=%b want=1", done); end
        n_cmp++; if (periods_done !== 8'd0) begin n_err++; $display("FAIL prio_pd got=%0d want=0", periods_done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL prio_busy got=%b want=0", busy); end
    endtask

    // P=2 H=1 N=0 for 600 clocks: periods_done wraps at the 256th period.
    task automatic test_wrap();
        logic              exp_s;
        logic [NPER_W-1:0] exp_pd;
        period_clocks = 12'd2; high_clocks = 12'd1; num_periods = 8'd0;
        start = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (i == 0) start = 1'b0;
            exp_s  = ((i % 2) == 0);
            exp_pd = NPER_W'((i / 2) % 256);
            n_cmp++; if (sinal !== exp_s) begin n_err++; $display("FAIL wrap_sinal i=%0d got=%b want=%b", i, sinal, exp_s); end
            n_cmp++; if (periods_done !== exp_pd) begin n_err++; $display("FAIL wrap_pd i=%0d got=%0d want=%0d", i, periods_done, exp_pd); end
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done got=%b want=1", done); end
    endtask

    // Asynchronous reset mid-HIGH; a new start is needed afterwards.
    task automatic test_async_reset();
        period_clocks = 12'd10; high_clocks = 12'd5; num_periods = 8'd0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (sinal !== 1'b0) begin n_err++; $display("FAIL areset_sinal got=%b want=0", sinal); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL areset_done got=%b want=0", done); end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++; if (sinal !== 1'b0) begin n_err++; $display("FAIL areset_idle_sinal i=%0d got=%b want=0", i, sinal); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_idle_busy i=%0d got=%b want=0", i, busy); end
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++; if (sinal !== 1'b1) begin n_err++; $display("FAIL areset_restart got=%b want=1", sinal); end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL areset_stop_done got=%b want=1", done); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_stop();
        test_stop_priority();
        test_wrap();
        test_async_reset();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/signal_period_generator.md
Name: signal_period_generator

Overview:
- Transmit-side counterpart of the signal-period counter: it emits a square wave `sinal` with a programmed period and high time, both in clock counts.
- Drives stimulus into the period counter, or acts as a standalone periodic-signal source.
- Emits a programmed number of periods, or runs continuously; reports progress and completion.

Parameters:
- CNT_W, 12, width of period/high-time fields; matches the counter's 12-bit measurement width.
- NPER_W, 8, width of the period-count field and the periods_done output.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin emission; sampled only in IDLE.
- stop  input  1  abort request; sampled in HIGH and LOW.
- period_clocks  input  CNT_W  total period P in clocks.
- high_clocks  input  CNT_W  high time H in clocks.
- num_periods  input  NPER_W  periods to emit N; 0 = continuous until stop.
- sinal  output  1  generated waveform, registered.
- busy  output  1  high in HIGH/LOW states.
- done  output  1  one-cycle pulse when N periods complete or stop is taken.
- cfg_error  output  1  sticky; set on rejected start, cleared by next accepted start.
- periods_done  output  NPER_W  completed full periods since the last accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; sinal=0, busy=0, done=0, cfg_error=0, periods_done=0, all internal counters 0.
- Config legality: 2 <= P and 1 <= H <= P-1.
- start in IDLE with legal config:
  - P, H and N are latched into internal registers; later input changes are ignored until the next IDLE.
  - Next state is HIGH, phase counter=1, sinal=1 on the following edge (latency 1 clock), periods_done=0, cfg_error=0.
- start in IDLE with illegal config: state stays IDLE, cfg_error=1, sinal stays 0, done is not pulsed.
- start outside IDLE: ignored.
- HIGH state: sinal=1. When phase==H, go to LOW, set sinal=0, phase=1. Otherwise phase+1. Exactly H cycles high.
- LOW state: sinal=0. Exactly P-H cycles low. When phase==P-H the period completes:
  - periods_done+1, wrapping modulo 2^NPER_W.
  - If N!=0 and the incremented count == N: go to IDLE, done=1 for one cycle, busy=0.
  - Otherwise: go to HIGH, phase=1, sinal=1 (no gap between periods).
- Rising-to-rising edge spacing is exactly P clocks. The high pulse width is exactly H clocks.
- stop in HIGH or LOW:
  - Next edge: state IDLE, sinal=0, done=1 for one cycle.
  - periods_done holds its value; the partial period is not counted.
- stop has priority over period completion in the same cycle.
- start and stop together in IDLE: start is taken and stop is ignored.
- Continuous mode (N=0): runs until stop; periods_done wraps 255→0 without effect on the waveform.
- Arithmetic: phase counter is CNT_W bits. P-H is computed at latch time into a CNT_W register, never negative because the config is legal. No overflow is possible since phase never exceeds P-1.
- Reset asserted mid-emission: immediate return to the reset values. No done pulse.

Decomposition:
- Shared package `periodo_pkg`:
  - state enum (IDLE, HIGH, LOW).
  - CNT_W default constant, shared with the period counter so widths agree.
- No sub-module required. The phase counter and FSM stay in one module.
- A loopback bench instantiates this block driving `sinal` of the existing period counter.

Test Plan:
- P=10, H=5, N=2, start pulse: sinal rises 1 clock after start; high 5 / low 5 twice; done pulses on the 20th clock after the first rise; periods_done=2; loopback counter reads 10.
- P=4, H=3, N=3: waveform 1110 repeated 3 times with no gaps; busy high for exactly 12 clocks; done once.
- Illegal config, checked in separate runs: P=5, H=5; P=1, H=0; H=0 → cfg_error=1, sinal stays 0, busy stays 0. A following legal start clears cfg_error.
- P=10, H=3, N=0, stop asserted on the 4th LOW cycle of period 3 → next clock sinal=0, done=1, periods_done=2, busy=0.
- N=0, P=2, H=1 run for 600 clocks: periods_done wraps 255→0 at the 256th period; waveform is uninterrupted.
- reset driven low mid-HIGH, asynchronously between edges → sinal=0 and busy=0 immediately, before the next clock edge; after release, start is required to resume.
